hazard_fwd_unit: RTL

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

---
 rtl/hazard_fwd_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/hazard_fwd_unit.sv
// Load-use hazard detection and EX operand-forwarding select generation for a
// 5-stage in-order pipeline, with a saturating count of load-use stall cycles.
module hazard_fwd_unit #(
  parameter int XLEN_SEL = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                id_valid,
  input  logic [4:0]          id_rs1,
  input  logic [4:0]          id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [4:0]          id_rd,
  input  logic                id_regwrite,
  input  logic                id_memread,
  input  logic                id_b_imm,
  input  logic                flush,
  output logic                stall,
  output logic [XLEN_SEL-1:0] fwd_a_sel,
  output logic [XLEN_SEL-1:0] fwd_b_sel,
  output logic                ex_valid,
  output logic [31:0]         stall_count
);

  localparam logic [XLEN_SEL-1:0] SEL_REGFILE = XLEN_SEL'(0);
  localparam logic [XLEN_SEL-1:0] SEL_EXMEM   = XLEN_SEL'(1);
  localparam logic [XLEN_SEL-1:0] SEL_MEMWB   = XLEN_SEL'(2);
  localparam logic [XLEN_SEL-1:0] SEL_IMM     = XLEN_SEL'(3);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } slot_t;

  typedef enum logic {
    RUN,
    LU_STALL
  } state_t;

  state_t state;
  state_t next_state;
  slot_t  ex_slot;
  slot_t  mem_slot;
  slot_t  wb_slot;
  slot_t  id_slot;
  slot_t  next_ex_slot;

  logic                issue;
  logic                load_use;
  logic [XLEN_SEL-1:0] next_a_sel;
  logic [XLEN_SEL-1:0] next_b_sel;

  // A slot can feed a source only if it really writes a nonzero register.
  function automatic logic produces(input slot_t s, input logic [4:0] rs);
    return s.valid && s.regwrite && (s.rd != 5'd0) && (s.rd == rs);
  endfunction

  function automatic logic [XLEN_SEL-1:0] src_sel(input slot_t ex_s, input slot_t mem_s,
                                                  input logic [4:0] rs, input logic used);
    if (!used)                  return SEL_REGFILE;
    else if (produces(ex_s, rs))  return SEL_EXMEM;
    else if (produces(mem_s, rs)) return SEL_MEMWB;
    else                        return SEL_REGFILE;
  endfunction

  assign id_slot = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    load_use   = ex_slot.memread &&
                 ((id_use_rs1 && produces(ex_slot, id_rs1)) ||
                  (id_use_rs2 && produces(ex_slot, id_rs2)));
    case (state)
      RUN: begin
        if (reset_n && id_valid && !flush && load_use) begin
          stall      = 1'b1;
          next_state = LU_STALL;
        end
      end
      LU_STALL: next_state = RUN;
      default:  next_state = RUN;
    endcase
  end

  always_comb begin
    issue        = id_valid && !stall && !flush;
    next_ex_slot = '0;
    next_a_sel   = SEL_REGFILE;
    next_b_sel   = SEL_REGFILE;
    if (issue) begin
      next_ex_slot = id_slot;
      next_a_sel   = src_sel(ex_slot, mem_slot, id_rs1, id_use_rs1);
      next_b_sel   = id_b_imm ? SEL_IMM : src_sel(ex_slot, mem_slot, id_rs2, id_use_rs2);
    end
  end

  // The WB slot tracks the retiring instruction; its result is assumed to be
  // visible in the register file by the time a later ID reads it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= RUN;
      ex_slot     <= '0;
      mem_slot    <= '0;
      wb_slot     <= '0;
      fwd_a_sel   <= SEL_REGFILE;
      fwd_b_sel   <= SEL_REGFILE;
      stall_count <= '0;
    end else begin
      state     <= next_state;
      ex_slot   <= next_ex_slot;
      mem_slot  <= ex_slot;
      wb_slot   <= mem_slot;
      fwd_a_sel <= next_a_sel;
      fwd_b_sel <= next_b_sel;
      if (stall && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end

  assign ex_valid = ex_slot.valid;

endmodule
